lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage_pkg.sv | 48 ++++
 rtl/lsu_stage_if.sv | 30 +++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_stage.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_stage.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage_pkg
// Description : Shared definitions for the load/store stage. Holds the
//               memory base address default, the RV64 funct3 size codes,
//               the FSM state encoding and small decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_stage_pkg;

    // Physical address that maps to memory doubleword index 0.
    localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;

    // RV64 load/store funct3 size/sign codes.
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Low address bits that must be zero for a size-aligned access
    // (access size in bytes minus one).
    function automatic logic [2:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Reserved size code, or a store using an unsigned-load code.
    function automatic logic op_illegal(input logic store, input logic [2:0] funct3);
        return (funct3 == F3_BAD) || (store && funct3[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage_if
// Description : Memory bus between the load/store stage and data memory.
// Ports       : master - lsu side  : drives mem_req/mem_wen/mem_idx/
//                                     mem_wdata/mem_wmask, samples
//                                     mem_ack/mem_rdata
//               slave  - memory side: the reverse
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_stage_if;
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_idx;
    logic [63:0] mem_wdata;
    logic [63:0] mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_idx, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_idx, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane steering. Packs store data into its
//               doubleword lanes with a bit-level write mask, and unpacks a
//               read doubleword into a right-aligned, size-truncated,
//               sign- or zero-extended result.
// Ports       : funct3      - size/sign code
//               offset      - byte lane of the access (addr[2:0])
//               store_data  - right-aligned store data
//               store_wdata - store data shifted into its lanes
//               store_wmask - one mask bit per data bit
//               load_raw    - doubleword returned by memory
//               load_data   - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] store_data,
    output logic [63:0] store_wdata,
    output logic [63:0] store_wmask,
    input  logic [63:0] load_raw,
    output logic [63:0] load_data
);

    logic [5:0]  w_shamt;
    logic [7:0]  w_byte_mask;
    logic [7:0]  w_lane_mask;
    logic [63:0] w_shifted;

    always_comb begin
        w_shamt     = {offset, 3'b000};
        store_wdata = store_data << w_shamt;

        case (funct3[1:0])
            2'b00:   w_byte_mask = 8'h01;
            2'b01:   w_byte_mask = 8'h03;
            2'b10:   w_byte_mask = 8'h0F;
            default: w_byte_mask = 8'hFF;
        endcase
        w_lane_mask = w_byte_mask << offset;

        store_wmask = '0;
        for (int i = 0; i < 8; i++) begin
            store_wmask[8*i +: 8] = {8{w_lane_mask[i]}};
        end

        w_shifted = load_raw >> w_shamt;
        case (funct3)
            F3_B:    load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_D:    load_data = w_shifted;
            F3_BU:   load_data = {56'd0, w_shifted[7:0]};
            F3_HU:   load_data = {48'd0, w_shifted[15:0]};
            F3_WU:   load_data = {32'd0, w_shifted[31:0]};
            default: load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : Single-outstanding RV64 load/store unit. Accepts one request
//               from the execute stage, issues one memory access (with an
//               ack timeout), and returns one response to writeback.
//               Optional build macro LSU_MISALIGN_CHECK_EN turns misaligned
//               accesses into error responses; without it the address is
//               aligned down to the access size.
// Ports       : clock, reset             - clock, synchronous active-high reset
//               in_valid/in_ready         - request handshake
//               in_store, in_funct3, in_addr, in_wdata, in_rd - request
//               mem (lsu_stage_if.master) - data memory bus
//               out_valid/out_ready       - response handshake
//               out_rdata, out_rd, out_wen, out_err - response
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter logic [63:0] MEM_BASE    = MEM_BASE_DEFAULT,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_addr,
    input  logic [63:0]       in_wdata,
    input  logic [4:0]        in_rd,

    lsu_stage_if.master       mem,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_rdata,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_err
);

    localparam int          CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_store;
    logic [2:0]        r_funct3;
    logic [63:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [4:0]        r_rd;
    logic              r_err;
    logic [63:0]       r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic [2:0]        w_size_mask;
    logic [63:0]       w_aligned_addr;
    logic              w_op_err;
    logic              w_timeout;
    logic [63:0]       w_store_wdata;
    logic [63:0]       w_store_wmask;
    logic [63:0]       w_load_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept       = in_valid && (r_state == ST_IDLE);
    assign w_size_mask    = size_mask(in_funct3);
    assign w_aligned_addr = in_addr & ~{61'd0, w_size_mask};

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_misaligned;
    assign w_misaligned = |(in_addr[2:0] & w_size_mask);
    assign w_op_err     = op_illegal(in_store, in_funct3) || w_misaligned;
`else
    assign w_op_err     = op_illegal(in_store, in_funct3);
`endif

    // Last permitted REQ cycle passed without an ack.
    assign w_timeout = (r_state == ST_REQ) && !mem.mem_ack && (r_cnt == CNT_LAST);

    // Shared lane steering: packs the latched store, unpacks the read data.
    lsu_align u_align (
        .funct3      (r_funct3),
        .offset      (r_addr[2:0]),
        .store_data  (r_wdata),
        .store_wdata (w_store_wdata),
        .store_wmask (w_store_wmask),
        .load_raw    (mem.mem_rdata),
        .load_data   (w_load_data)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_op_err ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= 5'd0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_store  <= in_store;
                        r_funct3 <= in_funct3;
                        r_addr   <= w_aligned_addr;
                        r_wdata  <= in_wdata;
                        r_rd     <= in_rd;
                        r_err    <= w_op_err;
                        r_rdata  <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        r_rdata <= r_store ? 64'd0 : w_load_data;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Everything outside its owning state reads as zero.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready      = (r_state == ST_IDLE);

        mem.mem_req   = 1'b0;
        mem.mem_wen   = 1'b0;
        mem.mem_idx   = '0;
        mem.mem_wdata = '0;
        mem.mem_wmask = '0;
        if (r_state == ST_REQ) begin
            mem.mem_req = 1'b1;
            mem.mem_wen = r_store;
            mem.mem_idx = (r_addr - MEM_BASE) >> 3;
            if (r_store) begin
                mem.mem_wdata = w_store_wdata;
                mem.mem_wmask = w_store_wmask;
            end
        end

        out_valid = 1'b0;
        out_rdata = '0;
        out_rd    = 5'd0;
        out_wen   = 1'b0;
        out_err   = 1'b0;
        if (r_state == ST_RESP) begin
            out_valid = 1'b1;
            out_rdata = r_rdata;
            out_rd    = r_rd;
            out_wen   = !r_store && !r_err;
            out_err   = r_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_stage
// Description : Directed self-checking bench for lsu_stage.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    lsu_stage_if mem_bus ();

    lsu_stage #(
        .MEM_BASE    (BASE),
        .ACK_TIMEOUT (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_store  (in_store),
        .in_funct3 (in_funct3),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .mem       (mem_bus.master),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .out_err   (out_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        in_rd     = rd;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp_idx,
                           input logic [63:0] exp_data);
        issue(1'b0, f3, addr, 64'd0, 5'd9);
        check({tag, "_req"},   mem_bus.mem_req, 1);
        check({tag, "_wen"},   mem_bus.mem_wen, 0);
        check({tag, "_idx"},   mem_bus.mem_idx, exp_idx);
        check({tag, "_early"}, out_valid, 0);
        mem_bus.mem_rdata = rdata;
        mem_bus.mem_ack   = 1'b1;
        step();
        mem_bus.mem_ack   = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_rdata"}, out_rdata, exp_data);
        check({tag, "_owen"},  out_wen, 1);
        check({tag, "_err"},   out_err, 0);
        check({tag, "_rd"},    out_rd, 9);
        check({tag, "_reqlo"}, mem_bus.mem_req, 0);
        drain();
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wd, input logic [63:0] exp_idx,
                            input logic [63:0] exp_mask, input logic [63:0] exp_wdata);
        issue(1'b1, f3, addr, wd, 5'd4);
        check({tag, "_req"},   mem_bus.mem_req, 1);
        check({tag, "_wen"},   mem_bus.mem_wen, 1);
        check({tag, "_idx"},   mem_bus.mem_idx, exp_idx);
        check({tag, "_mask"},  mem_bus.mem_wmask, exp_mask);
        check({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
        check({tag, "_rdy"},   in_ready, 0);
        mem_bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        mem_bus.mem_ack   = 1'b1;
        step();
        mem_bus.mem_ack   = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_owen"},  out_wen, 0);
        check({tag, "_rdata"}, out_rdata, 0);
        check({tag, "_err"},   out_err, 0);
        drain();
        check({tag, "_idle"},  in_ready, 1);
    endtask

    task automatic do_illegal(input string tag, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr);
        issue(st, f3, addr, 64'h55, 5'd12);
        check({tag, "_req"},   mem_bus.mem_req, 0);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_err"},   out_err, 1);
        check({tag, "_owen"},  out_wen, 0);
        check({tag, "_rdata"}, out_rdata, 0);
        drain();
    endtask

    initial begin
        reset             = 1'b1;
        in_valid          = 1'b0;
        in_store          = 1'b0;
        in_funct3         = 3'd0;
        in_addr           = '0;
        in_wdata          = '0;
        in_rd             = 5'd0;
        out_ready         = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        // Reset state
        step();
        check("rst_in_ready",  in_ready, 1);
        check("rst_mem_req",   mem_bus.mem_req, 0);
        check("rst_mem_wen",   mem_bus.mem_wen, 0);
        check("rst_mem_idx",   mem_bus.mem_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wen",   out_wen, 0);
        check("rst_out_err",   out_err, 0);
        check("rst_out_rdata", out_rdata, 0);
        reset = 1'b0;
        step();

        // Ack while idle is ignored
        mem_bus.mem_ack = 1'b1;
        step();
        step();
        mem_bus.mem_ack = 1'b0;
        check("idle_ack_valid", out_valid, 0);
        check("idle_ack_ready", in_ready, 1);

        // Stores
        do_store("sb", 3'b000, BASE + 64'd5,  64'hAB, 64'd0,
                 64'h0000_FF00_0000_0000, 64'h0000_AB00_0000_0000);
        do_store("sw", 3'b010, BASE + 64'hC,  64'hDEAD_BEEF, 64'd1,
                 64'hFFFF_FFFF_0000_0000, 64'hDEAD_BEEF_0000_0000);
        do_store("sd", 3'b011, BASE + 64'h10, 64'h1122_3344_5566_7788, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788);

        // Loads
        do_load("lh",  3'b001, BASE + 64'hA,  64'h0000_0000_8001_0000, 64'd1, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lwu", 3'b110, BASE + 64'h4,  64'hF000_0000_1234_5678, 64'd0, 64'h0000_0000_F000_0000);
        do_load("lw",  3'b010, BASE + 64'h4,  64'hF000_0000_1234_5678, 64'd0, 64'hFFFF_FFFF_F000_0000);
        do_load("lb",  3'b000, BASE + 64'h13, 64'h0000_0000_8000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 3'b100, BASE + 64'h13, 64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_0000_0080);
        do_load("lhu", 3'b101, BASE + 64'h6,  64'hBEEF_0000_0000_0000, 64'd0, 64'h0000_0000_0000_BEEF);
        do_load("ld",  3'b011, BASE + 64'h18, 64'h0123_4567_89AB_CDEF, 64'd3, 64'h0123_4567_89AB_CDEF);

        // Ack timeout: 16 request cycles, then error; late ack ignored
        issue(1'b0, 3'b011, BASE + 64'h10, 64'd0, 5'd6);
        for (int i = 0; i < 15; i++) step();
        check("to_req_16th", mem_bus.mem_req, 1);
        check("to_not_yet",  out_valid, 0);
        step();
        check("to_valid", out_valid, 1);
        check("to_err",   out_err, 1);
        check("to_owen",  out_wen, 0);
        check("to_req",   mem_bus.mem_req, 0);
        mem_bus.mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        mem_bus.mem_ack   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_hold_valid", out_valid, 1);
            check("to_hold_err",   out_err, 1);
            check("to_hold_rdata", out_rdata, 0);
            check("to_hold_rd",    out_rd, 6);
        end
        mem_bus.mem_ack = 1'b0;
        // Response handshake with a new request pending: no same-cycle accept
        in_valid  = 1'b1;
        in_store  = 1'b0;
        in_funct3 = 3'b011;
        in_addr   = BASE;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("resp_no_accept_rdy", in_ready, 1);
        check("resp_no_accept_req", mem_bus.mem_req, 0);
        step();
        in_valid = 1'b0;
        check("after_idle_accept", mem_bus.mem_req, 1);
        mem_bus.mem_rdata = 64'h0;
        mem_bus.mem_ack   = 1'b1;
        step();
        mem_bus.mem_ack   = 1'b0;
        drain();

        // Illegal operations
        do_illegal("f3_111",  1'b0, 3'b111, BASE);
        do_illegal("st_bu",   1'b1, 3'b100, BASE);
        do_illegal("st_wu",   1'b1, 3'b110, BASE);

        // Misaligned doubleword
`ifdef LSU_MISALIGN_CHECK_EN
        do_illegal("ld_mis", 1'b0, 3'b011, BASE + 64'h4);
        do_illegal("sh_mis", 1'b1, 3'b001, BASE + 64'h3);
`else
        do_load("ld_mis", 3'b011, BASE + 64'h4, 64'hCAFE_F00D_1234_5678, 64'd0, 64'hCAFE_F00D_1234_5678);
        do_store("sh_mis", 3'b001, BASE + 64'h3, 64'h1234, 64'd0,
                 64'h0000_0000_FFFF_0000, 64'h0000_0000_1234_0000);
`endif

        // Reset during REQ abandons the transaction
        issue(1'b0, 3'b011, BASE, 64'd0, 5'd3);
        check("rreq_req", mem_bus.mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rreq_ready", in_ready, 1);
        check("rreq_mreq",  mem_bus.mem_req, 0);
        check("rreq_valid", out_valid, 0);
        mem_bus.mem_ack = 1'b1;
        out_ready = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                seen = seen | out_valid;
            end
            check("rreq_no_resp", seen, 0);
        end
        mem_bus.mem_ack = 1'b0;
        out_ready = 1'b0;

        // Reset during RESP drops the response
        issue(1'b0, 3'b111, BASE, 64'd0, 5'd3);
        check("rresp_valid", out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rresp_gone",  out_valid, 0);
        check("rresp_err",   out_err, 0);
        check("rresp_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
